// File: rtl/arb_pkg.sv
// Shared definitions for the data-side bus arbiter.
//   owner_t      : bus owner encoding (none / CPU MEM stage / UART DMA loader)
//   DEF_*        : default widths, DataMem/Peripheral boundary and burst limit
//   BURST_CNT_W  : width of the per-owner beat counter (covers MAX_BURST up to 16)
//   STALL_CNT_W  : width of the optional CPU stall counter
package arb_pkg;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_LIMIT = 256;
    localparam int DEF_MAX_BURST = 4;
    localparam int BURST_CNT_W   = 4;
    localparam int STALL_CNT_W   = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;
endpackage

// File: rtl/arb_addr_decode.sv
// Address decode and read-data select for the data-side bus.
// Also usable stand-alone wherever a master needs the same DataMem/Peripheral
// split (e.g. the CPU's own read-data select).
//   addr_i      : byte address being decoded
//   mem_rdata_i : DataMem read data
//   per_rdata_i : Peripheral read data
//   sel_mem_o   : address below MEM_LIMIT (DataMem)
//   sel_per_o   : address at or above MEM_LIMIT (Peripheral)
//   rdata_o     : read data of the selected slave
module arb_addr_decode
    import arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_LIMIT = DEF_MEM_LIMIT
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [DATA_W-1:0] per_rdata_i,
    output logic              sel_mem_o,
    output logic              sel_per_o,
    output logic [DATA_W-1:0] rdata_o
);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_LIMIT);

    assign sel_mem_o = (addr_i < LIMIT);
    assign sel_per_o = ~sel_mem_o;
    assign rdata_o   = sel_mem_o ? mem_rdata_i : per_rdata_i;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-side bus (DataMem below MEM_LIMIT,
// Peripheral at or above it). Port 0 is the CPU MEM stage, port 1 the UART
// DMA loader. Registered grant, round-robin on ties, bounded bursts under
// contention, registered read data back to the owner.
//
// Handshake: reqX is a valid that the master holds, together with
// wrX/addrX/wdataX, until a beat occurs; gntX acts as ready. A beat is any
// cycle with gntX=1 and reqX=1 and consumes exactly one command.
//
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   req*/wr*/addr*/wdata*    : master command inputs (0 = CPU, 1 = DMA)
//   gnt*                     : registered bus ownership
//   rvalid*/rdata*           : read data, valid the cycle after a read beat
//   cpu_stall                : req0 & ~gnt0, combinational
//   mem_*                    : DataMem strobes/address/data, combinational read
//   per_*                    : Peripheral strobes/address/data
//   dbg_owner                : current owner state for observation
//   stall_cnt                : saturating CPU stall counter, only when the
//                              ARB_STALL_CNT_EN macro is defined
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_LIMIT = DEF_MEM_LIMIT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   wr0,
    input  logic                   wr1,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [DATA_W-1:0]      wdata0,
    input  logic [DATA_W-1:0]      wdata1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   rvalid0,
    output logic                   rvalid1,
    output logic [DATA_W-1:0]      rdata0,
    output logic [DATA_W-1:0]      rdata1,
    output logic                   cpu_stall,
`ifdef ARB_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   per_rd,
    output logic                   per_wr,
    output logic [ADDR_W-1:0]      per_addr,
    output logic [DATA_W-1:0]      per_wdata,
    input  logic [DATA_W-1:0]      per_rdata,
    output owner_t                 dbg_owner
);
    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

    owner_t                 owner_q, owner_d;
    owner_t                 rr_last_q, rr_last_d;
    logic [BURST_CNT_W-1:0] burst_q, burst_d;
    logic                   gnt0_q, gnt1_q;
    logic                   rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]      rdata0_q, rdata1_q;

    logic                   beat0, beat1, beat;
    logic                   own_req, oth_req;
    owner_t                 oth_owner;
    logic                   bus_wr;
    logic [ADDR_W-1:0]      bus_addr;
    logic [DATA_W-1:0]      bus_wdata;
    logic [DATA_W-1:0]      bus_rdata;
    logic                   sel_mem, sel_per;

    assign beat0 = gnt0_q & req0;
    assign beat1 = gnt1_q & req1;
    assign beat  = beat0 | beat1;

    // Owner's command onto the shared bus; zero while nobody owns it.
    always_comb begin
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (owner_q)
            OWN_CPU: begin
                bus_wr    = wr0;
                bus_addr  = addr0;
                bus_wdata = wdata0;
            end
            OWN_DMA: begin
                bus_wr    = wr1;
                bus_addr  = addr1;
                bus_wdata = wdata1;
            end
            default: ;
        endcase
    end

    arb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LIMIT (MEM_LIMIT)
    ) u_decode (
        .addr_i      (bus_addr),
        .mem_rdata_i (mem_rdata),
        .per_rdata_i (per_rdata),
        .sel_mem_o   (sel_mem),
        .sel_per_o   (sel_per),
        .rdata_o     (bus_rdata)
    );

    assign mem_rd    = beat & ~bus_wr & sel_mem;
    assign mem_wr    = beat &  bus_wr & sel_mem;
    assign per_rd    = beat & ~bus_wr & sel_per;
    assign per_wr    = beat &  bus_wr & sel_per;
    assign mem_addr  = bus_addr;
    assign mem_wdata = bus_wdata;
    assign per_addr  = bus_addr;
    assign per_wdata = bus_wdata;

    // Requests seen from the current owner's point of view.
    assign own_req   = (owner_q == OWN_CPU) ? req0 : req1;
    assign oth_req   = (owner_q == OWN_CPU) ? req1 : req0;
    assign oth_owner = (owner_q == OWN_CPU) ? OWN_DMA : OWN_CPU;

    always_comb begin
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        burst_d   = burst_q;
        case (owner_q)
            OWN_NONE: begin
                burst_d = '0;
                if (req0 && req1) begin
                    owner_d = (rr_last_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
                end else if (req0) begin
                    owner_d = OWN_CPU;
                end else if (req1) begin
                    owner_d = OWN_DMA;
                end
            end
            OWN_CPU, OWN_DMA: begin
                // Release when the owner is done, or when its last allowed
                // beat under contention is happening now. Handing straight
                // to the waiting port avoids an idle bubble.
                if (!own_req || (burst_q == BURST_LAST && oth_req)) begin
                    rr_last_d = owner_q;
                    burst_d   = '0;
                    owner_d   = oth_req ? oth_owner : OWN_NONE;
                end else if (burst_q != BURST_LAST) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q   <= OWN_NONE;
            rr_last_q <= OWN_DMA;
            burst_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            burst_q   <= burst_d;
            gnt0_q    <= (owner_d == OWN_CPU);
            gnt1_q    <= (owner_d == OWN_DMA);
            rvalid0_q <= beat0 & ~bus_wr;
            rvalid1_q <= beat1 & ~bus_wr;
            if (beat0 && !bus_wr) begin
                rdata0_q <= bus_rdata;
            end
            if (beat1 && !bus_wr) begin
                rdata1_q <= bus_rdata;
            end
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign cpu_stall = req0 & ~gnt0_q;
    assign dbg_owner = owner_q;

`ifdef ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (cpu_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge. Read data expected by
// the masters is queued when the read beat is issued and popped on rvalid.
// Define ARB_STALL_CNT_EN to also exercise the stall counter.
module tb_mem_bus_arbiter;
  import arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, cpu_stall;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_rd, mem_wr, per_rd, per_wr;
  logic [AW-1:0] mem_addr, per_addr;
  logic [DW-1:0] mem_wdata, per_wdata, mem_rdata, per_rdata;
  owner_t        dbg_owner;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .cpu_stall (cpu_stall),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .per_rd    (per_rd),
    .per_wr    (per_wr),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_rdata (per_rdata),
    .dbg_owner (dbg_owner)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic check_rdata(input string tag, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %08h expected nothing queued", tag, act);
    end else begin
      e = exp_q.pop_front();
      check(tag, act, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic dma_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, mem_rd, mem_wr, per_rd, per_wr};
  endfunction

  function automatic logic [31:0] gnts();
    return {30'd0, gnt0, gnt1};
  endfunction

  initial begin
    // ---------------- clock/reset ----------------
    reset = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0; per_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnts(), 0);
    check("rst_rvalid", {30'd0, rvalid0, rvalid1}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_strobes", strobes(), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_per_wdata", per_wdata, 0);
    check("rst_owner", 32'(dbg_owner), 32'(OWN_NONE));

    // ---------------- CPU-only read ----------------
    next_cycle(); reset = 0; cpu_cmd(0, 32'h10, 0); mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_c1_gnt0", gnt0, 0);
    check("rd_c1_stall", cpu_stall, 1);
    check("rd_c1_strobes", strobes(), 0);
    next_cycle();
    @(negedge clk);
    exp_q.push_back(32'hDEADBEEF);
    check("rd_c2_gnt0", gnt0, 1);
    check("rd_c2_strobes", strobes(), 32'b1000);
    check("rd_c2_mem_addr", mem_addr, 32'h10);
    check("rd_c2_stall", cpu_stall, 0);
    next_cycle(); req0 = 0;
    @(negedge clk);
    check("rd_c3_rvalid0", rvalid0, 1);
    check_rdata("rd_c3_rdata0", rdata0);
    check("rd_c3_strobes", strobes(), 0);

    // ---------------- decode boundary ----------------
    next_cycle(); cpu_cmd(1, 32'hFC, 32'h11111111);
    @(negedge clk);
    check("dec_idle_gnt0", gnt0, 0);
    check("dec_idle_rvalid0", rvalid0, 0);
    check("dec_idle_addr_zero", mem_addr, 0);
    next_cycle();
    @(negedge clk);
    check("dec_fc_strobes", strobes(), 32'b0100);
    check("dec_fc_wdata", mem_wdata, 32'h11111111);
    next_cycle(); cpu_cmd(1, 32'h100, 32'h22222222);
    @(negedge clk);
    check("dec_100_strobes", strobes(), 32'b0001);
    check("dec_100_per_addr", per_addr, 32'h100);
    check("dec_100_per_wdata", per_wdata, 32'h22222222);
    check("dec_wr_no_rvalid", rvalid0, 0);
    next_cycle(); cpu_cmd(1, 32'h40000010, 32'h33333333);
    @(negedge clk);
    check("dec_hi_strobes", strobes(), 32'b0001);
    next_cycle(); cpu_cmd(0, 32'h200, 0); per_rdata = 32'hCAFEF00D;
    @(negedge clk);
    exp_q.push_back(32'hCAFEF00D);
    check("dec_per_rd_strobes", strobes(), 32'b0010);
    next_cycle(); req0 = 0;
    @(negedge clk);
    check("dec_per_rvalid0", rvalid0, 1);
    check_rdata("dec_per_rdata0", rdata0);

    // ---------------- tie from reset ----------------
    next_cycle(); reset = 1;
    @(negedge clk);
    check("tie_rst_owner", 32'(dbg_owner), 32'(OWN_NONE));
    next_cycle(); reset = 0;
    cpu_cmd(0, 32'h8, 0); dma_cmd(0, 32'h20, 0); mem_rdata = 32'h12345678;
    @(negedge clk);
    check("tie_c1_gnt", gnts(), 0);
    next_cycle();
    @(negedge clk);
    exp_q.push_back(32'h12345678);
    check("tie_c2_cpu_first", gnts(), 32'b10);
    next_cycle(); req0 = 0;
    @(negedge clk);
    check("tie_c3_gnt", gnts(), 32'b10);
    check("tie_c3_rvalid0", rvalid0, 1);
    check_rdata("tie_c3_rdata0", rdata0);
    check("tie_c3_no_beat", strobes(), 0);
    next_cycle();
    @(negedge clk);
    exp_q.push_back(32'h12345678);
    check("tie_c4_dma_gnt", gnts(), 32'b01);
    check("tie_c4_strobes", strobes(), 32'b1000);
    check("tie_c4_mem_addr", mem_addr, 32'h20);
    next_cycle(); req1 = 0;
    @(negedge clk);
    check("tie_c5_rvalid1", rvalid1, 1);
    check_rdata("tie_c5_rdata1", rdata1);
    next_cycle(); cpu_cmd(1, 32'h50, 32'h5); dma_cmd(1, 32'h60, 32'h6);
    @(negedge clk);
    check("tie2_idle_gnt", gnts(), 0);
    next_cycle();
    @(negedge clk);
    check("tie2_cpu_wins", gnts(), 32'b10);
    check("tie2_mem_addr", mem_addr, 32'h50);
    next_cycle(); req0 = 0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("tie2_dma_next", gnts(), 32'b01);
    check("tie2_dma_addr", mem_addr, 32'h60);
    next_cycle(); req1 = 0;
    @(negedge clk);

    // ---------------- burst limit ----------------
    next_cycle(); dma_cmd(1, 32'h30, 32'hAAAA0000);
    @(negedge clk);
    check("bu_idle_gnt", gnts(), 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      wdata1 = 32'hAAAA0000 + 32'(i);
      if (i == 0) begin
        cpu_cmd(0, 32'h44, 0);
        mem_rdata = 32'h0BADF00D;
      end
      @(negedge clk);
      check($sformatf("bu_beat%0d_gnt", i), gnts(), 32'b01);
      check($sformatf("bu_beat%0d_strobes", i), strobes(), 32'b0100);
      check($sformatf("bu_beat%0d_wdata", i), mem_wdata, 32'hAAAA0000 + 32'(i));
      check($sformatf("bu_beat%0d_stall", i), cpu_stall, 1);
    end
    next_cycle(); wdata1 = 32'hAAAA0004;
    @(negedge clk);
    exp_q.push_back(32'h0BADF00D);
    check("bu_cpu_gnt", gnts(), 32'b10);
    check("bu_cpu_strobes", strobes(), 32'b1000);
    check("bu_cpu_addr", mem_addr, 32'h44);
    check("bu_cpu_stall", cpu_stall, 0);
    next_cycle(); req0 = 0;
    @(negedge clk);
    check("bu_rvalid0", rvalid0, 1);
    check_rdata("bu_rdata0", rdata0);
    next_cycle();
    @(negedge clk);
    check("bu_dma_back", gnts(), 32'b01);
    check("bu_dma_wdata", mem_wdata, 32'hAAAA0004);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("bu_hold%0d_gnt", i), gnts(), 32'b01);
    end
    next_cycle(); req1 = 0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("bu_release_gnt", gnts(), 0);

    // ---------------- reset mid-read ----------------
    next_cycle(); cpu_cmd(0, 32'h10, 0); mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("mr_beat_strobes", strobes(), 32'b1000);
    reset = 1;
    next_cycle();
    @(negedge clk);
    check("mr_rvalid0", rvalid0, 0);
    check("mr_gnt0", gnt0, 0);
    next_cycle(); reset = 0;
    @(negedge clk);
    check("mr_deassert_gnt0", gnt0, 0);
    next_cycle();
    @(negedge clk);
    exp_q.push_back(32'h55AA55AA);
    check("mr_regrant_gnt0", gnt0, 1);
    check("mr_regrant_strobes", strobes(), 32'b1000);
    next_cycle(); req0 = 0;
    @(negedge clk);
    check("mr_rvalid0_after", rvalid0, 1);
    check_rdata("mr_rdata0_after", rdata0);

`ifdef ARB_STALL_CNT_EN
    // ---------------- stall counter ----------------
    next_cycle(); reset = 1;
    @(negedge clk);
    check("sc_rst", stall_cnt, 0);
    next_cycle(); reset = 0; cpu_cmd(1, 32'h4, 32'h1);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("sc_after_one", stall_cnt, 1);
    next_cycle(); req0 = 0;
    @(negedge clk);
    next_cycle(); cpu_cmd(1, 32'h8, 32'h2); dma_cmd(1, 32'h70, 32'h3);
    @(negedge clk);
    repeat (5) begin
      next_cycle();
      @(negedge clk);
    end
    check("sc_burst_gnt0", gnt0, 1);
    check("sc_burst_cnt", stall_cnt, 6);
    // DMA keeps requesting; CPU requests only while not granted, so four of
    // every five cycles are stall cycles: 87500 cycles give 70000 stalls.
    for (int i = 0; i < 87500; i++) begin
      next_cycle();
      req0 = ~gnt0;
    end
    @(negedge clk);
    check("sc_saturate", stall_cnt, 32'hFFFF);
    req0 = 0; req1 = 0;
`endif

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-side bus (DataMem below MEM_LIMIT, Peripheral at or above it) between two masters: port 0 is the pipeline CPU MEM stage, port 1 is the UART program/data loader (DMA).
- Registered-grant arbiter with bounded burst locking and round-robin fairness.
- Produces a combinational stall for the CPU pipeline and returns registered read data to the owner.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LIMIT, 256, byte-address boundary; addr < MEM_LIMIT selects DataMem, otherwise Peripheral.
- MAX_BURST, 4, maximum consecutive beats an owner keeps while the other port requests; legal range 1..16.

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- req0/req1 in 1: bus request, CPU/DMA.
- wr0/wr1 in 1: 1 = write, 0 = read.
- addr0/addr1 in ADDR_W: byte address.
- wdata0/wdata1 in DATA_W: write data.
- gnt0/gnt1 out 1: registered bus ownership.
- rvalid0/rvalid1 out 1: one-cycle read-data-valid pulse.
- rdata0/rdata1 out DATA_W: registered read data.
- cpu_stall out 1: req0 & ~gnt0 (combinational).
- mem_rd/mem_wr out 1: DataMem strobes.
- mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W: DataMem bus, combinational read.
- per_rd/per_wr out 1: Peripheral strobes.
- per_addr out ADDR_W; per_wdata out DATA_W; per_rdata in DATA_W: Peripheral bus.

Behaviour:
- State: owner ∈ {NONE, CPU, DMA}; rr_last ∈ {CPU, DMA}; burst_cnt 4 bits.
- Reset values: owner=NONE, rr_last=DMA (CPU wins the first tie), burst_cnt=0. gnt*, rvalid*, rdata*, and all strobes are 0. Address/wdata outputs are 0.
- Reset asserted mid-transaction: the in-flight beat is dropped and no rvalid is produced.
- Beat: any cycle with gnt_X=1 and req_X=1.
  - The master's current wr/addr/wdata is routed to exactly one slave, selected by the addr decode.
  - Exactly one of mem_rd/mem_wr/per_rd/per_wr is high per beat. All strobes are 0 in non-beat cycles.
- Latency:
  - req rises in cycle N with owner NONE → gnt high in N+1, first beat in N+1.
  - Read beat in cycle K → rdata_X and rvalid_X valid in K+1. Writes produce no rvalid.
- Masters hold req/wr/addr/wdata stable until a beat occurs; each beat consumes one command.
- owner NONE, next edge:
  - Both requesting → grant the port ≠ rr_last.
  - One requesting → grant it.
  - None requesting → stay NONE.
  - On any grant, burst_cnt ← 0.
- owner X, each beat increments burst_cnt. Release at the edge when:
  - (a) req_X=0 in this cycle, or
  - (b) the beat has burst_cnt=MAX_BURST-1 and the other port requests.
- On release:
  - rr_last ← X.
  - If the other port requests, owner ← other with gnt_other high the next cycle (no idle bubble), burst_cnt ← 0.
  - Otherwise owner ← NONE.
- Without contention, an owner keeps the bus indefinitely; burst_cnt saturates at MAX_BURST-1.
- gnt0 and gnt1 are never both 1.
- Address/wdata outputs mux the owner's signals whenever owner ≠ NONE; otherwise they are 0.

Optional Feature:
- ARB_STALL_CNT_EN defined:
  - Adds output stall_cnt[15:0], which increments every cycle cpu_stall=1.
  - Saturates at 16'hFFFF; cleared only by reset.
- ARB_STALL_CNT_EN undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package arb_pkg:
  - owner_t enum {OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2}.
  - Default MEM_LIMIT constant.
  - Width constants.
- One sub-module, arb_addr_decode: combinational addr → {sel_mem, sel_per} plus the read-data mux. It is reused by the CPU's own read-data select.
- All state stays in mem_bus_arbiter.

Test Plan:
- Reset, then CPU-only read: req0=1, addr0=0x10 in cycle 1, mem_rdata=0xDEADBEEF → gnt0=1 in cycle 2 with mem_rd=1, mem_addr=0x10; rvalid0=1, rdata0=0xDEADBEEF in cycle 3; cpu_stall=1 only in cycle 1.
- Decode boundary: write addr0=0xFC → mem_wr=1, per_wr=0. Write addr0=0x100 (=MEM_LIMIT) → per_wr=1, mem_wr=0. Write addr0=0x40000010 → per_wr=1.
- Tie from reset: req0=req1=1 in the same cycle → gnt0 first. After CPU releases, DMA is granted the next cycle, and a second simultaneous tie goes to CPU (rr_last=DMA).
- Burst limit, MAX_BURST=4: DMA holds req1, CPU raises req0 → exactly 4 DMA beats, gnt1 falls, gnt0 rises the next cycle with no idle cycle; cpu_stall high throughout the wait.
- Reset mid-read: assert reset in the cycle of a read beat → rvalid0 stays 0 and gnt0=0. After deassert, the re-request is granted in 1 cycle.
- ARB_STALL_CNT_EN: CPU waits through a 4-beat DMA burst starting from an idle bus → stall_cnt=5. Force 70000 stall cycles → stall_cnt=0xFFFF.
